// File: rtl/dbuf_pkg.sv
// rtl/dbuf_pkg.sv - shared constants and per-channel state type for the digital buffer filter
package dbuf_pkg;

    localparam int DBUF_SYNC_MIN  = 2;
    localparam int DBUF_SYNC_MAX  = 4;
    // Widest deglitch counter any instance may use; narrower counters live in the low bits.
    localparam int DBUF_CNT_MAXW  = 16;

    typedef struct packed {
        logic                     st;
        logic [DBUF_CNT_MAXW-1:0] cnt;
    } dbuf_ch_st_t;

endpackage

// File: rtl/dbuf_filt_ch.sv
// rtl/dbuf_filt_ch.sv - one channel: synchroniser chain, deglitch counter, filtered state and change pulse
module dbuf_filt_ch
    import dbuf_pkg::*;
#(
    parameter int CNTW        = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i,
    input  logic [CNTW-1:0] flt_len,
    input  logic            hold,
    output logic            st,
    output logic            chg,
    output logic            busy,
    output logic [CNTW-1:0] cnt
);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     synced;
    dbuf_ch_st_t              r;
    logic [DBUF_CNT_MAXW-1:0] len_ext;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign len_ext = DBUF_CNT_MAXW'(flt_len);

    // Synchroniser shift chain; keeps running while the filter is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i};
        end
    end

    // Deglitch filter: st follows synced only after flt_len+1 consecutive mismatch cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r.st  <= RST_VAL;
            r.cnt <= '0;
            chg   <= 1'b0;
        end else if (hold) begin
            r.cnt <= '0;
            chg   <= 1'b0;
        end else if (synced == r.st) begin
            r.cnt <= '0;
            chg   <= 1'b0;
        end else if (r.cnt >= len_ext) begin
            // >= so that lowering flt_len mid-count resolves on the very next edge.
            r.st  <= synced;
            r.cnt <= '0;
            chg   <= 1'b1;
        end else begin
            r.cnt <= r.cnt + DBUF_CNT_MAXW'(1);
            chg   <= 1'b0;
        end
    end

    assign st   = r.st;
    assign cnt  = r.cnt[CNTW-1:0];
    assign busy = (synced != r.st) && !hold;

endmodule

// File: rtl/dbuf_filt_multi.sv
// rtl/dbuf_filt_multi.sv - NCH-channel synchronising deglitch buffer with polarity and freeze control
module dbuf_filt_multi
    import dbuf_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNTW        = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            CELV,
    input  logic            CELG,
    input  logic            SUB,
    input  logic [NCH-1:0]  i,
    input  logic [CNTW-1:0] flt_len,
    input  logic [NCH-1:0]  inv,
    input  logic [NCH-1:0]  hold,
    output logic [NCH-1:0]  o,
    output logic [NCH-1:0]  chg,
    output logic [NCH-1:0]  busy
);

    logic [NCH-1:0]  st;
    logic [CNTW-1:0] cnt [NCH];

    // Supply pins are carried through the hierarchy for connectivity only.
    logic supply_unused;
    assign supply_unused = CELV ^ CELG ^ SUB;

    genvar n;
    generate
        for (n = 0; n < NCH; n++) begin : g_ch
            dbuf_filt_ch #(
                .CNTW        (CNTW),
                .SYNC_STAGES (SYNC_STAGES),
                .RST_VAL     (RST_VAL)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .i       (i[n]),
                .flt_len (flt_len),
                .hold    (hold[n]),
                .st      (st[n]),
                .chg     (chg[n]),
                .busy    (busy[n]),
                .cnt     (cnt[n])
            );

            // A change pulse can only repeat back-to-back when filtering is bypassed.
            a_chg_pulse : assert property (@(posedge clk) disable iff (rst)
                chg[n] |=> (!chg[n] || flt_len == '0));

            // The counter is bounded by the length in force when it was last advanced.
            a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
                cnt[n] <= $past(flt_len));
        end
    endgenerate

    // Polarity is applied after the filter so toggling inv never produces a chg pulse.
    assign o = st ^ inv;

    a_sync_range : assert property (@(posedge clk)
        SYNC_STAGES >= DBUF_SYNC_MIN && SYNC_STAGES <= DBUF_SYNC_MAX);

    a_cntw_range : assert property (@(posedge clk)
        CNTW >= 1 && CNTW <= DBUF_CNT_MAXW);

endmodule

// File: tb/tb_dbuf_filt_multi.sv
// tb/tb_dbuf_filt_multi.sv - scoreboard bench for dbuf_filt_multi
module tb_dbuf_filt_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i;
    logic [3:0] flt_len;
    logic [3:0] inv;
    logic [3:0] hold;
    logic [3:0] o;
    logic [3:0] chg;
    logic [3:0] busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] o;
        logic [3:0] chg;
    } exp_t;

    exp_t sb[$];

    dbuf_filt_multi #(
        .NCH         (4),
        .CNTW        (4),
        .SYNC_STAGES (2),
        .RST_VAL     (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .CELV    (1'b1),
        .CELG    (1'b0),
        .SUB     (1'b0),
        .i       (i),
        .flt_len (flt_len),
        .inv     (inv),
        .hold    (hold),
        .o       (o),
        .chg     (chg),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue an expectation dly cycles after the current check point.
    task automatic exp_at(input int dly, input string tag, input logic [3:0] eo, input logic [3:0] ec);
        exp_t e;
        e.cyc = cyc + dly;
        e.tag = tag;
        e.o   = eo;
        e.chg = ec;
        sb.push_back(e);
    endtask

    // Advance one clock and compare every expectation due at this cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk({e.tag, "_due"}, 32'(e.cyc), 32'(cyc));
            chk({e.tag, "_o"},   32'(o),     32'(e.o));
            chk({e.tag, "_chg"}, 32'(chg),   32'(e.chg));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst     = 1'b1;
        i       = 4'b0000;
        flt_len = 4'd0;
        inv     = 4'b0101;
        hold    = 4'b0000;

        // Reset with inverted polarity on channels 0 and 2
        run(2);
        rst = 1'b0;
        chk("rst_o",    32'(o),    32'(4'b0101));
        chk("rst_chg",  32'(chg),  32'(4'b0000));
        chk("rst_busy", 32'(busy), 32'(4'b0000));
        inv = 4'b0000;
        #1;
        chk("inv_o",   32'(o),   32'(4'b0000));
        chk("inv_chg", 32'(chg), 32'(4'b0000));
        run(2);

        // Bypass: two-edge latency through the synchroniser
        flt_len = 4'd0;
        i[0] = 1'b1;
        exp_at(2, "byp_pre",  4'b0000, 4'b0000);
        exp_at(3, "byp_hit",  4'b0001, 4'b0001);
        exp_at(4, "byp_post", 4'b0001, 4'b0000);
        run(5);

        // Deglitch: 5-wide pulse rejected with L=5
        flt_len = 4'd5;
        i[1] = 1'b1;
        for (int d = 1; d <= 12; d++) exp_at(d, "glitch", 4'b0001, 4'b0000);
        run(5);
        i[1] = 1'b0;
        run(8);

        // Deglitch: 6-wide pulse accepted, then the fall qualifies the same way
        i[1] = 1'b1;
        exp_at(7,  "dg_pre",  4'b0001, 4'b0000);
        exp_at(8,  "dg_rise", 4'b0011, 4'b0010);
        exp_at(9,  "dg_post", 4'b0011, 4'b0000);
        exp_at(13, "dg_fpre", 4'b0011, 4'b0000);
        exp_at(14, "dg_fall", 4'b0001, 4'b0010);
        exp_at(15, "dg_fpst", 4'b0001, 4'b0000);
        run(6);
        i[1] = 1'b0;
        run(10);

        // Hold: channel 2 frozen while its input is high
        flt_len = 4'd3;
        hold[2] = 1'b1;
        i[2]    = 1'b1;
        for (int d = 1; d <= 10; d++) exp_at(d, "hold", 4'b0001, 4'b0000);
        run(10);
        chk("hold_busy", 32'(busy), 32'(4'b0000));
        hold[2] = 1'b0;
        #1;
        chk("rel_busy", 32'(busy), 32'(4'b0100));
        exp_at(3, "rel_pre",  4'b0001, 4'b0000);
        exp_at(4, "rel_hit",  4'b0101, 4'b0100);
        exp_at(5, "rel_post", 4'b0101, 4'b0000);
        run(6);

        // Reset mid-qualification on channel 3, then full re-qualification of all high inputs
        flt_len = 4'd8;
        i[3] = 1'b1;
        exp_at(6, "mid_pre", 4'b0101, 4'b0000);
        run(6);
        rst = 1'b1;
        exp_at(1, "mid_rst1", 4'b0000, 4'b0000);
        exp_at(2, "mid_rst2", 4'b0000, 4'b0000);
        run(2);
        rst = 1'b0;
        exp_at(10, "req_pre",  4'b0000, 4'b0000);
        exp_at(11, "req_hit",  4'b1101, 4'b1101);
        exp_at(12, "req_post", 4'b1101, 4'b0000);
        run(13);

        // Multi-channel: all inputs toggle together with L=2
        flt_len = 4'd2;
        i = 4'b0010;
        exp_at(4, "mc_pre",  4'b1101, 4'b0000);
        exp_at(5, "mc_hit",  4'b0010, 4'b1111);
        exp_at(6, "mc_post", 4'b0010, 4'b0000);
        run(7);

        // flt_len lowered 7->1 while counters sit at 4: update on the next edge
        flt_len = 4'd7;
        i = 4'b1101;
        exp_at(6, "fl_pre", 4'b0010, 4'b0000);
        run(6);
        flt_len = 4'd1;
        exp_at(1, "fl_hit",  4'b1101, 4'b1111);
        exp_at(2, "fl_post", 4'b1101, 4'b0000);
        run(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
